sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//  Single-clock FIFO buffer between a producer and a consumer in the same clock domain.
//  Build-time selectable read style:
//   - standard: registered read, 1-cycle latency after rd_en
//   - FWFT (first-word-fall-through / show-ahead): head word already on rd_data whenever !empty; rd_en pops it.
//  Exposes full, empty and an occupancy count.
// PARAMETERS
//  WIDTH       32            data word width in bits
//  DEPTH       16            number of entries; must be a power of two, >= 2
//  FWFT_MODE   0             0 = standard registered read, 1 = FWFT
//  ADDR_WIDTH  $clog2(DEPTH) derived (localparam); pointer width
// PORTS
//  clk      in   1             single clock, all state updates on rising edge
//  rst      in   1             reset: synchronous, active-high
//  wr_en    in   1             write request
//  wr_data  in   WIDTH         write data, sampled when write accepted
//  full     out  1             count == DEPTH
//  rd_en    in   1             read/pop request
//  rd_data  out  WIDTH         read data (see BEHAVIOUR)
//  empty    out  1             count == 0
//  count    out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (rst=1 at posedge clk):
//   - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_data=0
//   - memory contents not cleared
//   - applies mid-operation: all stored words discarded
//  Write accepted (wr_ok) iff wr_en && !full:
//   - mem[wr_ptr] <= wr_data; wr_ptr wraps DEPTH-1 -> 0
//  Read accepted (rd_ok) iff rd_en && !empty:
//   - rd_ptr increments, wraps DEPTH-1 -> 0
//  Gating is on pre-edge flags:
//   - full && wr_en && rd_en: read only
//   - empty && wr_en && rd_en: write only
//  Count update:
//   - count += wr_ok - rd_ok (both accepted: unchanged)
//   - full, empty derived from registered count; valid the cycle after the causing edge
//  Overflow (write while full) and underflow (read while empty):
//   - silently ignored; no state change; count never exceeds DEPTH or goes below 0
//  FWFT_MODE=1:
//   - rd_data = mem[rd_ptr] combinationally whenever !empty; 0 when empty
//   - first written word visible in the same cycle empty falls, i.e. the cycle after the write edge
//   - after a rd_ok edge rd_data shows the next word (or 0 if now empty); zero added read latency
//  FWFT_MODE=0:
//   - rd_data is a register loaded with mem[rd_ptr] on the rd_ok edge
//   - holds its value otherwise, including when rd_en is set while empty
//  Simultaneous write and read at the same address (count==1 in FWFT):
//   - output shows the old head until the pop edge, then the new word
// STRUCTURE
//  - No shared package needed; ADDR_WIDTH is a local derived parameter.
//  - Natural sub-module: fifo_mem, a simple dual-port RAM (1 write port, 1 async read port, DEPTH x WIDTH).
//  - Top level holds pointers, count, flags and the FWFT_MODE generate branch for rd_data.
// TESTING (WIDTH=32, DEPTH=16; both FWFT_MODE values)
//  1. Reset 5 cycles -> empty=1, full=0, count=0.
//  2. FWFT: write 0xDEADBEEF, idle 1 cycle -> rd_data=0xDEADBEEF, empty=0; one rd_en pulse -> empty=1.
//  3. FWFT: write 0xCAFE0000..0xCAFE0003 -> rd_data=0xCAFE0000 before any read; each rd_en pulse advances rd_data by 1; empty=1 after 4 pops.
//  4. Write 0xBEEF0000..0xBEEF000F:
//     - full=1, count=16; extra write of 0xFFFFFFFF ignored, count stays 16
//     - 16 pops return 0xBEEF0000..000F in order; then empty=1, count=0
//  5. Read on empty -> empty stays 1, count 0, no pointer move.
//     Prefill 8 words, 5 cycles of wr_en&rd_en -> count stays 8, order preserved across pointer wrap.
//  6. 50-iteration random rd/wr vs scoreboard model; every cycle check:
//     - count <= DEPTH
//     - empty == (count==0)
//     - full == (count==DEPTH)
//     - data matches scoreboard

Source files
------------

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read port.
// Write lands on the clock edge; read is combinational from raddr. No flow control.
module fifo_mem #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with build-time standard (1-cycle registered) or show-ahead read.
// Writes while full and reads while empty are dropped without any state change.
module sync_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int FWFT_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [WIDTH-1:0]      head;
    logic                  wr_ok;
    logic                  rd_ok;

    // Gating uses the registered flags, so a full FIFO with both requests only reads.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    fifo_mem #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    generate
        if (FWFT_MODE != 0) begin : g_fwft
            assign rd_data = empty ? '0 : head;
        end else begin : g_std
            logic [WIDTH-1:0] rd_data_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q <= '0;
                end else if (rd_ok) begin
                    rd_data_q <= head;
                end
            end

            assign rd_data = rd_data_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

    localparam int W = 32;
    localparam int D = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [W-1:0]  wr_data;

    logic          full_s, empty_s, full_f, empty_f;
    logic [W-1:0]  rd_data_s, rd_data_f;
    logic [4:0]    count_s, count_f;

    always #5 clk = ~clk;

    sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT_MODE(0)) dut_std (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full_s),
        .rd_en   (rd_en),
        .rd_data (rd_data_s),
        .empty   (empty_s),
        .count   (count_s)
    );

    sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT_MODE(1)) dut_fwft (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full_f),
        .rd_en   (rd_en),
        .rd_data (rd_data_f),
        .empty   (empty_f),
        .count   (count_f)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: contents queue plus the expected standard-mode output register.
    logic [W-1:0] q [$];
    logic [W-1:0] std_exp;

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] d;
        int          c;
        logic        e;
        logic        f;
        logic [31:0] df;
        logic [31:0] ds;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic w, input logic r, input logic [31:0] d);
        bit wok;
        bit rok;
        wok = w && (q.size() < D);
        rok = r && (q.size() > 0);
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        @(posedge clk);
        #1;
        if (rok) std_exp = q.pop_front();
        if (wok) q.push_back(d);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        std_exp = '0;
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = q.size();
        chk({tag, " count_std"}, 32'(count_s), 32'(sz));
        chk({tag, " count_fwft"}, 32'(count_f), 32'(sz));
        chk({tag, " count_bound"}, 32'(count_f <= 5'(D)), 32'd1);
        chk({tag, " empty_std"}, 32'(empty_s), 32'(sz == 0));
        chk({tag, " empty_fwft"}, 32'(empty_f), 32'(sz == 0));
        chk({tag, " full_std"}, 32'(full_s), 32'(sz == D));
        chk({tag, " full_fwft"}, 32'(full_f), 32'(sz == D));
        chk({tag, " data_fwft"}, rd_data_f, (sz == 0) ? 32'h0 : q[0]);
        chk({tag, " data_std"}, rd_data_s, std_exp);
    endtask

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        std_exp = '0;

        // w, r, data, count, empty, full, fwft rd_data, std rd_data (after the edge)
        vecs[0]  = '{1'b1, 1'b0, 32'hDEADBEEF, 1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0,        0, 1'b1, 1'b0, 32'h0,        32'hDEADBEEF};
        vecs[3]  = '{1'b0, 1'b1, 32'h0,        0, 1'b1, 1'b0, 32'h0,        32'hDEADBEEF};
        vecs[4]  = '{1'b1, 1'b0, 32'hCAFE0000, 1, 1'b0, 1'b0, 32'hCAFE0000, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, 1'b0, 32'hCAFE0001, 2, 1'b0, 1'b0, 32'hCAFE0000, 32'hDEADBEEF};
        vecs[6]  = '{1'b1, 1'b1, 32'hCAFE0002, 2, 1'b0, 1'b0, 32'hCAFE0001, 32'hCAFE0000};
        vecs[7]  = '{1'b0, 1'b1, 32'h0,        1, 1'b0, 1'b0, 32'hCAFE0002, 32'hCAFE0001};
        vecs[8]  = '{1'b1, 1'b1, 32'hCAFE0003, 1, 1'b0, 1'b0, 32'hCAFE0003, 32'hCAFE0002};
        vecs[9]  = '{1'b0, 1'b1, 32'h0,        0, 1'b1, 1'b0, 32'h0,        32'hCAFE0003};
        vecs[10] = '{1'b1, 1'b1, 32'hCAFE0004, 1, 1'b0, 1'b0, 32'hCAFE0004, 32'hCAFE0003};
        vecs[11] = '{1'b0, 1'b1, 32'h0,        0, 1'b1, 1'b0, 32'h0,        32'hCAFE0004};

        do_reset(5);
        chk("reset empty_std", 32'(empty_s), 32'd1);
        chk("reset empty_fwft", 32'(empty_f), 32'd1);
        chk("reset full_std", 32'(full_s), 32'd0);
        chk("reset full_fwft", 32'(full_f), 32'd0);
        chk("reset count_std", 32'(count_s), 32'd0);
        chk("reset count_fwft", 32'(count_f), 32'd0);
        chk("reset data_std", rd_data_s, 32'h0);
        chk("reset data_fwft", rd_data_f, 32'h0);

        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].w, vecs[i].r, vecs[i].d);
            chk($sformatf("vec%0d count_std", i), 32'(count_s), 32'(vecs[i].c));
            chk($sformatf("vec%0d count_fwft", i), 32'(count_f), 32'(vecs[i].c));
            chk($sformatf("vec%0d empty", i), 32'({empty_s, empty_f}), 32'({vecs[i].e, vecs[i].e}));
            chk($sformatf("vec%0d full", i), 32'({full_s, full_f}), 32'({vecs[i].f, vecs[i].f}));
            chk($sformatf("vec%0d data_fwft", i), rd_data_f, vecs[i].df);
            chk($sformatf("vec%0d data_std", i), rd_data_s, vecs[i].ds);
        end

        // Fill to capacity; pointers wrap during this pass.
        for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, 32'hBEEF0000 + 32'(i));
        chk("fill full_std", 32'(full_s), 32'd1);
        chk("fill full_fwft", 32'(full_f), 32'd1);
        chk("fill count", 32'(count_f), 32'd16);
        cycle(1'b1, 1'b0, 32'hFFFFFFFF);
        chk("overflow count_std", 32'(count_s), 32'd16);
        chk("overflow count_fwft", 32'(count_f), 32'd16);
        chk("overflow head", rd_data_f, 32'hBEEF0000);
        for (int i = 0; i < D; i++) begin
            chk($sformatf("drain%0d fwft", i), rd_data_f, 32'hBEEF0000 + 32'(i));
            cycle(1'b0, 1'b1, 32'h0);
            chk($sformatf("drain%0d std", i), rd_data_s, 32'hBEEF0000 + 32'(i));
        end
        chk("drain empty", 32'({empty_s, empty_f}), 32'b11);
        chk("drain count", 32'(count_s), 32'd0);

        cycle(1'b0, 1'b1, 32'h0);
        chk("underflow count", 32'(count_s), 32'd0);
        chk("underflow empty", 32'(empty_f), 32'd1);
        chk("underflow std hold", rd_data_s, 32'hBEEF000F);

        // Full with both requests: read only.
        for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, 32'h5A000000 + 32'(i));
        cycle(1'b1, 1'b1, 32'h77777777);
        chk("full rw count", 32'(count_f), 32'd15);
        chk("full rw head", rd_data_f, 32'h5A000001);
        chk("full rw std", rd_data_s, 32'h5A000000);
        do_reset(1);

        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h10000000 + 32'(i));
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 32'h20000000 + 32'(i));
            chk($sformatf("steady%0d count", i), 32'(count_s), 32'd8);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 32'h0);
            chk($sformatf("steady_drain%0d std", i), rd_data_s,
                (i < 3) ? 32'h10000005 + 32'(i) : 32'h20000000 + 32'(i - 3));
        end

        // Reset mid-operation discards stored words.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h30000000 + 32'(i));
        cycle(1'b0, 1'b1, 32'h0);
        do_reset(1);
        chk("midreset count", 32'(count_f), 32'd0);
        chk("midreset empty", 32'({empty_s, empty_f}), 32'b11);
        chk("midreset data_std", rd_data_s, 32'h0);
        chk("midreset data_fwft", rd_data_f, 32'h0);
        cycle(1'b1, 1'b0, 32'h44444444);
        chk("postreset head", rd_data_f, 32'h44444444);
        chk("postreset count", 32'(count_s), 32'd1);

        for (int i = 0; i < 50; i++) begin
            logic w;
            logic r;
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            cycle(w, r, $urandom);
            check_model($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
